// File: rtl/spi_slave_rx_burst.sv
// SPI slave receive front-end: decodes address/command/data frames from the pins
// into register-file write strobes and transmitter read requests, with burst support.
module spi_slave_rx_burst #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ssn,
  input  logic              mosi,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              write_en,
  output logic              tx_req,
  output logic              rx_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int SHIFT_A  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int SHIFT_W  = (SHIFT_A > 8) ? SHIFT_A : 8;
  localparam int CNT_W    = $clog2(SHIFT_W + 1);
  localparam logic IDLE_SCLK   = (CPOL != 0);
  localparam logic SAMPLE_RISE = (((CPOL ^ CPHA) & 1) == 0);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CMD, S_WDATA, S_RDATA, S_HOLD} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, ssn_sync_reg, mosi_sync_reg;
  logic                   sclk_d_reg, ssn_d_reg;
  logic                   sclk_s, ssn_s, mosi_s;
  logic                   samp, ssn_fall, ssn_rise;

  // ssn stages reset low so an ssn already low at reset release never looks like a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_reg <= {SYNC_STAGES{IDLE_SCLK}};
      ssn_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      sclk_d_reg    <= IDLE_SCLK;
      ssn_d_reg     <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      ssn_sync_reg  <= {ssn_sync_reg[SYNC_STAGES-2:0], ssn};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      sclk_d_reg    <= sclk_s;
      ssn_d_reg     <= ssn_s;
    end
  end

  assign sclk_s   = sclk_sync_reg[SYNC_STAGES-1];
  assign ssn_s    = ssn_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign samp     = SAMPLE_RISE ? (sclk_s & ~sclk_d_reg) : (~sclk_s & sclk_d_reg);
  assign ssn_fall = ssn_d_reg & ~ssn_s;
  assign ssn_rise = ~ssn_d_reg & ssn_s;

  state_t              state_reg, state_next;
  logic [SHIFT_W-2:0]  shift_reg, shift_next;
  logic [CNT_W-1:0]    bitcnt_reg, bitcnt_next;
  logic [ADDR_W-1:0]   address_reg, address_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                burst_reg, burst_next;
  logic                word_done_reg, word_done_next;
  logic                write_en_reg, write_en_next;
  logic                tx_req_reg, tx_req_next;
  logic                rx_done_reg, rx_done_next;
  logic                frame_err_reg, frame_err_next;

  logic [SHIFT_W-1:0]  shift_shifted;
  logic [CNT_W-1:0]    bitcnt_inc;
  logic                addr_end, cmd_end, word_end, clean_end;

  assign shift_shifted = {shift_reg, mosi_s};
  assign bitcnt_inc    = bitcnt_reg + 1'b1;
  assign addr_end      = (bitcnt_inc == CNT_W'(ADDR_W));
  assign cmd_end       = (bitcnt_inc == CNT_W'(8));
  assign word_end      = (bitcnt_inc == CNT_W'(DATA_W));
  assign clean_end     = (state_reg == S_HOLD) ||
                         (((state_reg == S_WDATA) || (state_reg == S_RDATA)) &&
                          (bitcnt_reg == '0) && word_done_reg);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // ssn rising is checked first so a coincident samp is discarded
  always_comb begin
    state_next = state_reg;
    if (state_reg == S_IDLE) begin
      if (ssn_fall) state_next = S_ADDR;
    end else if (ssn_rise) begin
      state_next = S_IDLE;
    end else if (samp) begin
      case (state_reg)
        S_ADDR:  if (addr_end) state_next = S_CMD;
        S_CMD:   if (cmd_end) state_next = shift_shifted[7] ? S_RDATA : S_WDATA;
        S_WDATA: if (word_end && !burst_reg) state_next = S_HOLD;
        S_RDATA: if (word_end && !burst_reg) state_next = S_HOLD;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    shift_next     = shift_reg;
    bitcnt_next    = bitcnt_reg;
    address_next   = address_reg;
    data_next      = data_reg;
    burst_next     = burst_reg;
    word_done_next = word_done_reg;
    write_en_next  = 1'b0;
    tx_req_next    = 1'b0;
    rx_done_next   = 1'b0;
    frame_err_next = 1'b0;
    // burst write: the address moves on once the strobe for the current word has gone out
    if (write_en_reg && burst_reg) address_next = address_reg + 1'b1;
    if (state_reg == S_IDLE) begin
      if (ssn_fall) begin
        shift_next     = '0;
        bitcnt_next    = '0;
        word_done_next = 1'b0;
      end
    end else if (ssn_rise) begin
      rx_done_next   = clean_end;
      frame_err_next = !clean_end;
      bitcnt_next    = '0;
    end else if (samp && (state_reg != S_HOLD)) begin
      shift_next  = shift_shifted[SHIFT_W-2:0];
      bitcnt_next = bitcnt_inc;
      case (state_reg)
        S_ADDR: if (addr_end) begin
          address_next = shift_shifted[ADDR_W-1:0];
          bitcnt_next  = '0;
        end
        S_CMD: if (cmd_end) begin
          burst_next  = shift_shifted[6];
          tx_req_next = shift_shifted[7];
          bitcnt_next = '0;
        end
        S_WDATA: if (word_end) begin
          data_next      = shift_shifted[DATA_W-1:0];
          write_en_next  = 1'b1;
          word_done_next = 1'b1;
          bitcnt_next    = '0;
        end
        S_RDATA: if (word_end) begin
          word_done_next = 1'b1;
          bitcnt_next    = '0;
          if (burst_reg) begin
            address_next = address_reg + 1'b1;
            tx_req_next  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg     <= '0;
      bitcnt_reg    <= '0;
      address_reg   <= '0;
      data_reg      <= '0;
      burst_reg     <= 1'b0;
      word_done_reg <= 1'b0;
      write_en_reg  <= 1'b0;
      tx_req_reg    <= 1'b0;
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      shift_reg     <= shift_next;
      bitcnt_reg    <= bitcnt_next;
      address_reg   <= address_next;
      data_reg      <= data_next;
      burst_reg     <= burst_next;
      word_done_reg <= word_done_next;
      write_en_reg  <= write_en_next;
      tx_req_reg    <= tx_req_next;
      rx_done_reg   <= rx_done_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign address   = address_reg;
  assign data      = data_reg;
  assign write_en  = write_en_reg;
  assign tx_req    = tx_req_reg;
  assign rx_done   = rx_done_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_spi_slave_rx_burst.sv
// Directed bench for spi_slave_rx_burst: one instance per SPI mode, each with its own pins.
module tb_spi_slave_rx_burst;

  localparam int H = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b1;
  logic       sclk_w [4];
  logic       ssn_w [4];
  logic       mosi_w [4];
  logic [7:0] address_w [4];
  logic [15:0] data_w [4];
  logic       write_en_w [4];
  logic       tx_req_w [4];
  logic       rx_done_w [4];
  logic       frame_err_w [4];
  logic       busy_w [4];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      spi_slave_rx_burst #(
        .ADDR_W(8), .DATA_W(16), .CPOL(gi / 2), .CPHA(gi % 2), .SYNC_STAGES(2)
      ) dut (
        .clk(clk), .rst(rst), .sclk(sclk_w[gi]), .ssn(ssn_w[gi]), .mosi(mosi_w[gi]),
        .address(address_w[gi]), .data(data_w[gi]), .write_en(write_en_w[gi]),
        .tx_req(tx_req_w[gi]), .rx_done(rx_done_w[gi]), .frame_err(frame_err_w[gi]),
        .busy(busy_w[gi])
      );
    end
  endgenerate

  // strobe recorder, one set of counters and logs per instance
  int         we_cnt [4];
  int         tx_cnt [4];
  int         done_cnt [4];
  int         err_cnt [4];
  logic [7:0] we_addr [4][8];
  logic [15:0] we_data [4][8];
  logic [7:0] tx_addr [4][8];

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (clr) begin
        we_cnt[m] <= 0; tx_cnt[m] <= 0; done_cnt[m] <= 0; err_cnt[m] <= 0;
      end else begin
        if (write_en_w[m]) begin
          if (we_cnt[m] < 8) begin
            we_addr[m][we_cnt[m]] <= address_w[m];
            we_data[m][we_cnt[m]] <= data_w[m];
          end
          we_cnt[m] <= we_cnt[m] + 1;
        end
        if (tx_req_w[m]) begin
          if (tx_cnt[m] < 8) tx_addr[m][tx_cnt[m]] <= address_w[m];
          tx_cnt[m] <= tx_cnt[m] + 1;
        end
        if (rx_done_w[m]) done_cnt[m] <= done_cnt[m] + 1;
        if (frame_err_w[m]) err_cnt[m] <= err_cnt[m] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    @(posedge clk); clr = 1'b1;
    @(posedge clk); clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic spi_bit(input int m, input logic b);
    if (m % 2 == 0) begin
      mosi_w[m] = b; #H;
      sclk_w[m] = ~sclk_w[m]; #H;
      sclk_w[m] = ~sclk_w[m];
    end else begin
      sclk_w[m] = ~sclk_w[m]; mosi_w[m] = b; #H;
      sclk_w[m] = ~sclk_w[m]; #H;
    end
  endtask

  task automatic spi_bits(input int m, input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) spi_bit(m, v[i]);
  endtask

  task automatic frame_start(input int m);
    ssn_w[m] = 1'b0; #H;
  endtask

  task automatic frame_end(input int m);
    #H; ssn_w[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic write_frame(input int m, input logic [7:0] a, input logic [15:0] d);
    frame_start(m);
    spi_bits(m, {8'h00, a}, 8);
    spi_bits(m, 16'h0000, 8);
    spi_bits(m, d, 16);
    frame_end(m);
  endtask

  initial begin
    for (int m = 0; m < 4; m++) begin
      sclk_w[m] = (m / 2 == 1);
      ssn_w[m]  = 1'b1;
      mosi_w[m] = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("rst_address", address_w[0], 8'h00);
    check("rst_data", data_w[0], 16'h0000);
    check("rst_write_en", write_en_w[0], 1'b0);
    check("rst_tx_req", tx_req_w[0], 1'b0);
    check("rst_rx_done", rx_done_w[0], 1'b0);
    check("rst_frame_err", frame_err_w[0], 1'b0);
    check("rst_busy", busy_w[0], 1'b0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // single write, mode 0
    clear_mon();
    frame_start(0);
    check("t1_busy", busy_w[0], 1'b1);
    spi_bits(0, 16'h003C, 8);
    spi_bits(0, 16'h0000, 8);
    spi_bits(0, 16'hA55A, 16);
    frame_end(0);
    check("t1_we_cnt", we_cnt[0], 1);
    check("t1_addr", we_addr[0][0], 8'h3C);
    check("t1_data", we_data[0][0], 16'hA55A);
    check("t1_tx_cnt", tx_cnt[0], 0);
    check("t1_done", done_cnt[0], 1);
    check("t1_err", err_cnt[0], 0);
    check("t1_busy_end", busy_w[0], 1'b0);

    // burst write wrapping through 0xFF
    clear_mon();
    frame_start(0);
    spi_bits(0, 16'h00FE, 8);
    spi_bits(0, 16'h0040, 8);
    spi_bits(0, 16'h1111, 16);
    spi_bits(0, 16'h2222, 16);
    spi_bits(0, 16'h3333, 16);
    frame_end(0);
    check("t2_we_cnt", we_cnt[0], 3);
    check("t2_addr0", we_addr[0][0], 8'hFE);
    check("t2_addr1", we_addr[0][1], 8'hFF);
    check("t2_addr2", we_addr[0][2], 8'h00);
    check("t2_data0", we_data[0][0], 16'h1111);
    check("t2_data1", we_data[0][1], 16'h2222);
    check("t2_data2", we_data[0][2], 16'h3333);
    check("t2_done", done_cnt[0], 1);
    check("t2_err", err_cnt[0], 0);

    // burst read of three words
    clear_mon();
    frame_start(0);
    spi_bits(0, 16'h0010, 8);
    spi_bits(0, 16'h00C0, 8);
    for (int w = 0; w < 3; w++) spi_bits(0, 16'hFFFF, 16);
    frame_end(0);
    check("t3_tx_ge3", (tx_cnt[0] >= 3), 1'b1);
    check("t3_tx0", tx_addr[0][0], 8'h10);
    check("t3_tx1", tx_addr[0][1], 8'h11);
    check("t3_tx2", tx_addr[0][2], 8'h12);
    check("t3_we_cnt", we_cnt[0], 0);
    check("t3_done", done_cnt[0], 1);
    check("t3_err", err_cnt[0], 0);

    // same single write in modes 1..3
    for (int m = 1; m < 4; m++) begin
      clear_mon();
      write_frame(m, 8'h3C, 16'hA55A);
      check("t4_we_cnt", we_cnt[m], 1);
      check("t4_addr", we_addr[m][0], 8'h3C);
      check("t4_data", we_data[m][0], 16'hA55A);
      check("t4_done", done_cnt[m], 1);
    end

    // abort after 5 data bits, then a good frame
    clear_mon();
    frame_start(0);
    spi_bits(0, 16'h0022, 8);
    spi_bits(0, 16'h0000, 8);
    spi_bits(0, 16'h0015, 5);
    frame_end(0);
    check("t5_err", err_cnt[0], 1);
    check("t5_we_cnt", we_cnt[0], 0);
    check("t5_done", done_cnt[0], 0);
    check("t5_busy", busy_w[0], 1'b0);
    clear_mon();
    write_frame(0, 8'h44, 16'hBEEF);
    check("t5b_we_cnt", we_cnt[0], 1);
    check("t5b_addr", we_addr[0][0], 8'h44);
    check("t5b_data", we_data[0][0], 16'hBEEF);
    check("t5b_done", done_cnt[0], 1);

    // reset mid-address with ssn held low
    clear_mon();
    frame_start(0);
    spi_bits(0, 16'h0002, 3);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_addr", address_w[0], 8'h00);
    check("t6_rst_data", data_w[0], 16'h0000);
    check("t6_rst_busy", busy_w[0], 1'b0);
    rst = 1'b0;
    spi_bits(0, 16'h001A, 5);
    check("t6_busy_idle", busy_w[0], 1'b0);
    spi_bits(0, 16'h0000, 8);
    spi_bits(0, 16'h1357, 16);
    frame_end(0);
    check("t6_we_cnt", we_cnt[0], 0);
    check("t6_done", done_cnt[0], 0);
    check("t6_err", err_cnt[0], 0);
    clear_mon();
    write_frame(0, 8'h5A, 16'h1234);
    check("t6b_we_cnt", we_cnt[0], 1);
    check("t6b_addr", we_addr[0][0], 8'h5A);
    check("t6b_data", we_data[0][0], 16'h1234);
    check("t6b_done", done_cnt[0], 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
